cart_detect: RTL and testbench

Streaming cartridge-type detector for the Atari 2600 core. It sits between the HPS ROM download port and the A2601top console core. It watches the same ioctl byte stream that fills the ROM dpram, measures the image, scans it for bank-switch signatures and Superchip RAM areas, and latches the `force_bs`, `sc` and `rom_size` values that A2601top consumes. A non-zero file-extension override and the OSD SuperChip setting always take priority over detection.

---
 rtl/cart_pkg.sv | 48 ++++
 rtl/cart_detect_if.sv | 29 ++
 rtl/cart_sig_match.sv | 73 +++++++
 rtl/cart_detect.sv | 240 ++++++++++++++++++++++++
 tb/tb_cart_detect.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/cart_pkg.sv
// -----------------------------------------------------------------------------
// cart_pkg
// Shared types and constants for the Atari 2600 cartridge-type detector:
//   bs_t      bank-switch scheme codes understood by A2601top (force_bs)
//   state_t   detector FSM states
//   SZ_*      ROM image sizes that map to a known bank-switch scheme
//   OP_*      opcode / operand bytes of the bank-switch signatures
// -----------------------------------------------------------------------------
package cart_pkg;

   typedef enum logic [3:0] {
      BS_NONE = 4'd0,
      BS_F8   = 4'd1,
      BS_F6   = 4'd2,
      BS_FE   = 4'd3,
      BS_E0   = 4'd4,
      BS_3F   = 4'd5,
      BS_F4   = 4'd6,
      BS_P2   = 4'd7,
      BS_FA   = 4'd8,
      BS_CV   = 4'd9
   } bs_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SCAN   = 2'd1,
      ST_DECIDE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam int SZ_2K  = 2048;
   localparam int SZ_4K  = 4096;
   localparam int SZ_8K  = 8192;
   localparam int SZ_12K = 12288;
   localparam int SZ_16K = 16384;
   localparam int SZ_32K = 32768;

   // 3F scheme: "STA $3F" = 85 3F
   localparam logic [7:0] OP_STA_ZP  = 8'h85;
   localparam logic [7:0] OP_3F_ZP   = 8'h3F;
   // E0 scheme: {STA|LDA|BIT} abs with address $1FE0..$1FE7
   localparam logic [7:0] OP_STA_ABS = 8'h8D;
   localparam logic [7:0] OP_LDA_ABS = 8'hAD;
   localparam logic [7:0] OP_BIT_ABS = 8'h2C;
   localparam logic [7:0] OP_E0_HI   = 8'h1F;
   localparam logic [4:0] OP_E0_LO5  = 5'b11100;  // top 5 bits of E0..E7

endpackage

// File: rtl/cart_detect_if.sv
// -----------------------------------------------------------------------------
// cart_detect_if
// HPS ROM-download (ioctl) byte stream as seen by the detector.
//   ioctl_download  high for the whole download
//   ioctl_wr        one-cycle byte strobe
//   ioctl_addr[25]  byte address
//   ioctl_dout[8]   byte data
// Modports: master = HPS side (drives), slave = detector side (observes).
// -----------------------------------------------------------------------------
interface cart_detect_if;
   logic        ioctl_download;
   logic        ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;

   modport master (
      output ioctl_download,
      output ioctl_wr,
      output ioctl_addr,
      output ioctl_dout
   );

   modport slave (
      input ioctl_download,
      input ioctl_wr,
      input ioctl_addr,
      input ioctl_dout
   );
endinterface

// File: rtl/cart_sig_match.sv
// -----------------------------------------------------------------------------
// cart_sig_match
// Byte history and saturating signature counters for bank-switch detection.
// The match window is the incoming byte plus the two previously accepted bytes,
// so a signature completing on the current byte is counted in the same cycle.
// Ports:
//   clk_sys, reset_n  clock, asynchronous active-low reset
//   clr_i             synchronous clear of history and counters (has priority)
//   en_i              accept byte_i into the history this cycle
//   byte_i[8]         incoming ROM byte
//   hit3f_o[2]        count of "85 3F" pairs, saturating at 3
//   hite0_o[2]        count of "{8D|AD|2C} E0..E7 1F" triples, saturating at 3
// -----------------------------------------------------------------------------
module cart_sig_match
   import cart_pkg::*;
(
   input  logic       clk_sys,
   input  logic       reset_n,
   input  logic       clr_i,
   input  logic       en_i,
   input  logic [7:0] byte_i,
   output logic [1:0] hit3f_o,
   output logic [1:0] hite0_o
);

   logic [1:0][7:0] hist_q, hist_d;   // [0] = previous byte, [1] = the one before
   logic [1:0]      hit3f_q, hit3f_d;
   logic [1:0]      hite0_q, hite0_d;
   logic            match_3f, match_e0;

   function automatic logic [1:0] sat_inc(input logic [1:0] v);
      return (v == 2'd3) ? v : v + 2'd1;
   endfunction

   always_comb begin
      match_3f = (hist_q[0] == OP_STA_ZP) && (byte_i == OP_3F_ZP);
      match_e0 = ((hist_q[1] == OP_STA_ABS) || (hist_q[1] == OP_LDA_ABS) ||
                  (hist_q[1] == OP_BIT_ABS)) &&
                 (hist_q[0][7:3] == OP_E0_LO5) &&
                 (byte_i == OP_E0_HI);
   end

   always_comb begin
      hist_d  = hist_q;
      hit3f_d = hit3f_q;
      hite0_d = hite0_q;
      if (clr_i) begin
         hist_d  = '0;
         hit3f_d = '0;
         hite0_d = '0;
      end else if (en_i) begin
         hist_d = {hist_q[0], byte_i};
         if (match_3f) hit3f_d = sat_inc(hit3f_q);
         if (match_e0) hite0_d = sat_inc(hite0_q);
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         hist_q  <= '0;
         hit3f_q <= '0;
         hite0_q <= '0;
      end else begin
         hist_q  <= hist_d;
         hit3f_q <= hit3f_d;
         hite0_q <= hite0_d;
      end
   end

   assign hit3f_o = hit3f_q;
   assign hite0_o = hite0_q;

endmodule

// File: rtl/cart_detect.sv
// -----------------------------------------------------------------------------
// cart_detect
// Streaming cartridge-type detector for the Atari 2600 core. Watches the ioctl
// ROM download, measures the image, counts bank-switch signatures and checks
// for Superchip RAM areas, then latches force_bs / sc / rom_size for A2601top.
// A non-zero ext_bs and a non-auto sc_mode override detection.
//
// Build option: define CART_DETECT_SC_EN to build the Superchip scan. Without
// it sc_ok is constant 0 and auto mode gives sc = ext_sc.
//
// Parameters:
//   MAX_AW          width of rom_size and of the tracked address
// Ports:
//   clk_sys         system clock (ioctl domain)
//   reset_n         asynchronous reset, active low
//   ioctl           ROM download stream (slave modport)
//   ext_bs[4]       bank-switch type from file extension, 0 = none
//   ext_sc          file name ends in "S"
//   sc_mode[2]      0 auto, 1 disable, 2 enable, 3 as 1
//   force_bs[4]     bank-switch type for A2601top
//   sc              Superchip enable
//   rom_size[MAX_AW] address of the last written byte
//   detect_done     high in DONE until the next download starts
// -----------------------------------------------------------------------------
module cart_detect
   import cart_pkg::*;
#(
   parameter int MAX_AW = 17
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   cart_detect_if.slave      ioctl,
   input  logic [3:0]        ext_bs,
   input  logic              ext_sc,
   input  logic [1:0]        sc_mode,
   output logic [3:0]        force_bs,
   output logic              sc,
   output logic [MAX_AW-1:0] rom_size,
   output logic              detect_done
);

   localparam int          NW       = MAX_AW + 1;
   localparam logic [24:0] ADDR_LIM = 25'((64'd1 << MAX_AW) - 64'd1);

   state_t state_q, state_d;
   logic   dl_q;
   logic   rise, fall, scan_wr, decide_en;

   logic [24:0]       expect_q, expect_d;
   logic              seq_err_q, seq_err_d;
   logic              oversize_q, oversize_d;
   logic [MAX_AW-1:0] last_q, last_d;

   logic [3:0]        force_bs_q, force_bs_d;
   logic              sc_q, sc_d;
   logic [MAX_AW-1:0] rom_size_q, rom_size_d;

   logic [1:0]        hit3f, hite0;
   logic              sc_ok;
   logic [NW-1:0]     n_sz;
   bs_t               det;

   // dl_q resets high so a download already in progress when reset is
   // released does not look like a fresh rising edge.
   assign rise    = ioctl.ioctl_download & ~dl_q;
   assign fall    = ~ioctl.ioctl_download & dl_q;
   assign scan_wr = (state_q == ST_SCAN) & ioctl.ioctl_wr;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         dl_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         dl_q    <= ioctl.ioctl_download;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      if (rise) begin
         state_d = ST_SCAN;
      end else begin
         case (state_q)
            ST_SCAN:   if (fall) state_d = ST_DECIDE;
            ST_DECIDE: state_d = ST_DONE;
            default:   state_d = state_q;
         endcase
      end
   end

   // ---------------- FSM: outputs ----------------
   // A restart arriving during DECIDE keeps the previous results.
   always_comb begin
      detect_done = (state_q == ST_DONE);
      decide_en   = (state_q == ST_DECIDE) & ~rise;
   end

   // ---------------- image measurement ----------------
   always_comb begin
      expect_d   = expect_q;
      seq_err_d  = seq_err_q;
      oversize_d = oversize_q;
      last_d     = last_q;
      if (rise) begin
         expect_d   = '0;
         seq_err_d  = 1'b0;
         oversize_d = 1'b0;
         last_d     = '0;
      end else if (scan_wr) begin
         if (ioctl.ioctl_addr != expect_q) seq_err_d  = 1'b1;
         if (ioctl.ioctl_addr > ADDR_LIM)  oversize_d = 1'b1;
         last_d   = (ioctl.ioctl_addr > ADDR_LIM) ? {MAX_AW{1'b1}}
                                                  : ioctl.ioctl_addr[MAX_AW-1:0];
         expect_d = ioctl.ioctl_addr + 25'd1;
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         expect_q   <= '0;
         seq_err_q  <= 1'b0;
         oversize_q <= 1'b0;
         last_q     <= '0;
      end else begin
         expect_q   <= expect_d;
         seq_err_q  <= seq_err_d;
         oversize_q <= oversize_d;
         last_q     <= last_d;
      end
   end

   cart_sig_match u_sig (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .clr_i   (rise),
      .en_i    (scan_wr),
      .byte_i  (ioctl.ioctl_dout),
      .hit3f_o (hit3f),
      .hite0_o (hite0)
   );

   // ---------------- Superchip scan ----------------
`ifdef CART_DETECT_SC_EN
   // Superchip images leave bytes 000..0FF of every 4K bank as RAM filler:
   // all equal to the byte at offset 0 of that bank.
   logic       sc_ok_q, sc_ok_d;
   logic [7:0] ref_q, ref_d;

   always_comb begin
      sc_ok_d = sc_ok_q;
      ref_d   = ref_q;
      if (rise) begin
         sc_ok_d = 1'b1;
         ref_d   = '0;
      end else if (scan_wr) begin
         if (ioctl.ioctl_addr[11:0] == 12'h000)
            ref_d = ioctl.ioctl_dout;
         else if ((ioctl.ioctl_addr[11:8] == 4'h0) && (ioctl.ioctl_dout != ref_q))
            sc_ok_d = 1'b0;
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         sc_ok_q <= 1'b1;
         ref_q   <= '0;
      end else begin
         sc_ok_q <= sc_ok_d;
         ref_q   <= ref_d;
      end
   end

   assign sc_ok = sc_ok_q;
`else
   assign sc_ok = 1'b0;
`endif

   // ---------------- decision ----------------
   function automatic bs_t decide_bs(input logic [NW-1:0] n,
                                     input logic [1:0]    h3f,
                                     input logic [1:0]    he0,
                                     input logic          bad);
      bs_t r;
      r = BS_NONE;
      if (bad) begin
         r = BS_NONE;
      end else if ((n == NW'(SZ_2K)) || (n == NW'(SZ_4K))) begin
         r = BS_NONE;
      end else if ((n == NW'(SZ_8K)) || (n == NW'(SZ_16K))) begin
         if (h3f >= 2'd2)      r = BS_3F;
         else if (he0 >= 2'd2) r = BS_E0;
         else if (n == NW'(SZ_8K)) r = BS_F8;
         else                  r = BS_F6;
      end else if (n == NW'(SZ_12K)) begin
         r = BS_FA;
      end else if (n == NW'(SZ_32K)) begin
         r = (h3f >= 2'd2) ? BS_3F : BS_F4;
      end
      return r;
   endfunction

   always_comb begin
      n_sz = NW'(last_q) + NW'(1);
      det  = decide_bs(n_sz, hit3f, hite0, seq_err_q | oversize_q);

      force_bs_d = force_bs_q;
      sc_d       = sc_q;
      rom_size_d = rom_size_q;
      if (decide_en) begin
         if (ext_bs != 4'd0) force_bs_d = ext_bs;
         else                force_bs_d = det;
         case (sc_mode)
            2'd0:    sc_d = ext_sc | (sc_ok & (n_sz >= NW'(SZ_8K)) & ~seq_err_q);
            2'd2:    sc_d = 1'b1;
            default: sc_d = 1'b0;
         endcase
         rom_size_d = last_q;
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         force_bs_q <= '0;
         sc_q       <= 1'b0;
         rom_size_q <= '0;
      end else begin
         force_bs_q <= force_bs_d;
         sc_q       <= sc_d;
         rom_size_q <= rom_size_d;
      end
   end

   assign force_bs = force_bs_q;
   assign sc       = sc_q;
   assign rom_size = rom_size_q;

endmodule

// File: tb/tb_cart_detect.sv
// -----------------------------------------------------------------------------
// tb_cart_detect
// Directed testbench for cart_detect. Streams synthetic ROM images through the
// ioctl interface and compares the latched outputs with hand-derived values.
// Superchip expectations follow the CART_DETECT_SC_EN build option.
// -----------------------------------------------------------------------------
module tb_cart_detect;

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic [3:0]  ext_bs;
   logic        ext_sc;
   logic [1:0]  sc_mode;
   logic [3:0]  force_bs;
   logic        sc;
   logic [16:0] rom_size;
   logic        detect_done;

   int n_tests = 0;
   int n_fail  = 0;

`ifdef CART_DETECT_SC_EN
   localparam logic [31:0] SC_BUILT = 32'd1;
`else
   localparam logic [31:0] SC_BUILT = 32'd0;
`endif

   cart_detect_if ioctl ();

   cart_detect #(.MAX_AW(17)) dut (
      .clk_sys     (clk_sys),
      .reset_n     (reset_n),
      .ioctl       (ioctl),
      .ext_bs      (ext_bs),
      .ext_sc      (ext_sc),
      .sc_mode     (sc_mode),
      .force_bs    (force_bs),
      .sc          (sc),
      .rom_size    (rom_size),
      .detect_done (detect_done)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   // Image patterns: 0 all EA; 1 E0 signatures at 0x100/0x1200;
   // 2 offsets 000..0FF of every bank = 00; 3 "85 3F" at 0x200/0x2200.
   function automatic logic [7:0] img_byte(input int mode, input int a);
      logic [7:0] b;
      b = 8'hEA;
      case (mode)
         1: begin
            if (a == 32'h100 || a == 32'h1200) b = 8'h8D;
            if (a == 32'h101 || a == 32'h1201) b = 8'hE0;
            if (a == 32'h102 || a == 32'h1202) b = 8'h1F;
         end
         2: if ((a % 4096) < 256) b = 8'h00;
         3: begin
            if (a == 32'h200 || a == 32'h2200) b = 8'h85;
            if (a == 32'h201 || a == 32'h2201) b = 8'h3F;
         end
         default: b = 8'hEA;
      endcase
      return b;
   endfunction

   task automatic start_dl();
      ioctl.ioctl_download = 1'b1;
      tick();
      tick();
   endtask

   task automatic stream(input int from, input int to, input int mode, input int skip,
                         input bit fall_last);
      for (int a = from; a < to; a++) begin
         if (a != skip) begin
            ioctl.ioctl_wr   = 1'b1;
            ioctl.ioctl_addr = 25'(a);
            ioctl.ioctl_dout = img_byte(mode, a);
            if (fall_last && a == to - 1) ioctl.ioctl_download = 1'b0;
            tick();
         end
      end
      ioctl.ioctl_wr = 1'b0;
   endtask

   task automatic finish_check(input string tag, input bit fell, input logic [31:0] e_bs,
                               input logic [31:0] e_sc, input logic [31:0] e_rom);
      if (!fell) begin
         ioctl.ioctl_download = 1'b0;
         tick();
      end
      check_val({tag, "_done_t1"}, 32'(detect_done), 32'd0);
      tick();
      check_val({tag, "_done_t2"}, 32'(detect_done), 32'd1);
      check_val({tag, "_force_bs"}, 32'(force_bs), e_bs);
      check_val({tag, "_sc"}, 32'(sc), e_sc);
      check_val({tag, "_rom_size"}, 32'(rom_size), e_rom);
   endtask

   initial begin
      reset_n              = 1'b0;
      ioctl.ioctl_download = 1'b0;
      ioctl.ioctl_wr       = 1'b0;
      ioctl.ioctl_addr     = '0;
      ioctl.ioctl_dout     = '0;
      ext_bs               = 4'd0;
      ext_sc               = 1'b0;
      sc_mode              = 2'd0;
      tick();
      tick();
      check_val("rst_force_bs", 32'(force_bs), 32'd0);
      check_val("rst_sc", 32'(sc), 32'd0);
      check_val("rst_rom_size", 32'(rom_size), 32'd0);
      check_val("rst_done", 32'(detect_done), 32'd0);
      reset_n = 1'b1;
      tick();

      // 4K all EA, last byte written in the same cycle as download end
      start_dl();
      stream(0, 4096, 0, -1, 1'b1);
      finish_check("4k", 1'b1, 32'd0, 32'd0, 32'h0FFF);

      // 8K with two E0 signatures; sc_mode 3 behaves as disable
      sc_mode = 2'd3;
      start_dl();
      stream(0, 8192, 1, -1, 1'b0);
      finish_check("8k_e0", 1'b0, 32'd4, 32'd0, 32'h1FFF);

      // 8K Superchip-style image, auto then disable
      sc_mode = 2'd0;
      start_dl();
      stream(0, 8192, 2, -1, 1'b0);
      finish_check("8k_sc_auto", 1'b0, 32'd1, SC_BUILT, 32'h1FFF);
      sc_mode = 2'd1;
      start_dl();
      stream(0, 8192, 2, -1, 1'b0);
      finish_check("8k_sc_off", 1'b0, 32'd1, 32'd0, 32'h1FFF);

      // 16K with two 3F signatures; extension override wins, ext_sc forces sc
      sc_mode = 2'd0;
      ext_bs  = 4'd2;
      ext_sc  = 1'b1;
      start_dl();
      stream(0, 16384, 3, -1, 1'b0);
      finish_check("16k_ovr", 1'b0, 32'd2, 32'd1, 32'h3FFF);

      // 32K: partial download, restart, then a full image
      ext_bs  = 4'd0;
      ext_sc  = 1'b0;
      sc_mode = 2'd2;
      start_dl();
      stream(0, 1000, 0, -1, 1'b0);
      ioctl.ioctl_download = 1'b0;
      tick();
      ioctl.ioctl_download = 1'b1;
      tick();
      check_val("restart_hold_bs", 32'(force_bs), 32'd2);
      check_val("restart_hold_sc", 32'(sc), 32'd1);
      check_val("restart_hold_rom", 32'(rom_size), 32'h3FFF);
      check_val("restart_done", 32'(detect_done), 32'd0);
      stream(0, 32768, 0, -1, 1'b0);
      finish_check("32k", 1'b0, 32'd6, 32'd1, 32'h7FFF);

      // 32K interrupted by reset: outputs clear at once and stay cleared
      start_dl();
      stream(0, 500, 0, -1, 1'b0);
      reset_n = 1'b0;
      #2;
      check_val("rstmid_force_bs", 32'(force_bs), 32'd0);
      check_val("rstmid_sc", 32'(sc), 32'd0);
      check_val("rstmid_done", 32'(detect_done), 32'd0);
      tick();
      reset_n = 1'b1;
      stream(500, 600, 0, -1, 1'b0);
      ioctl.ioctl_download = 1'b0;
      tick();
      tick();
      tick();
      check_val("rstend_done", 32'(detect_done), 32'd0);
      check_val("rstend_force_bs", 32'(force_bs), 32'd0);
      check_val("rstend_sc", 32'(sc), 32'd0);
      check_val("rstend_rom_size", 32'(rom_size), 32'd0);

      // 8K with address 0x0800 skipped: sequence error defeats detection
      sc_mode = 2'd0;
      start_dl();
      stream(0, 8192, 0, 32'h800, 1'b0);
      finish_check("8k_skip", 1'b0, 32'd0, 32'd0, 32'h1FFF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
